// File: rtl/pico9_pkg.sv
// Shared constants for the Pico9 I/O hub: widths, port addresses and status bit positions.
package pico9_pkg;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 9;
    localparam int unsigned PW  = 3;

    localparam logic [PW-1:0] IO_CH0   = 3'd0;
    localparam logic [PW-1:0] IO_CH1   = 3'd1;
    localparam logic [PW-1:0] IO_CH2   = 3'd2;
    localparam logic [PW-1:0] IO_CH3   = 3'd3;
    localparam logic [PW-1:0] IO_STAT  = 3'd4;
    localparam logic [PW-1:0] IO_MASK  = 3'd5;
    localparam logic [PW-1:0] IO_SCHED = 3'd6;
    localparam logic [PW-1:0] IO_OVR   = 3'd7;

    // Status word layout: {ovr_any, tx_valid[3:0], nonempty[3:0]}
    localparam int unsigned STAT_NE_LSB   = 0;
    localparam int unsigned STAT_TXV_LSB  = 4;
    localparam int unsigned STAT_OVR_BIT  = 8;
    localparam int unsigned SCHED_HIT_BIT = 8;

endpackage

// File: rtl/pico9_rx_fifo.sv
// Per-channel RX FIFO; push refused while full, pop ignored while empty.
module pico9_rx_fifo #(
    parameter int unsigned DW      = 9,
    parameter int unsigned RXDEPTH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          ready_c,
    output logic          nonempty_c,
    output logic [DW-1:0] head_c
);

    localparam int unsigned AW = (RXDEPTH > 1) ? $clog2(RXDEPTH) : 1;
    localparam int unsigned CW = $clog2(RXDEPTH + 1);

    logic [DW-1:0] mem [RXDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Fullness/emptiness come from the count at cycle start, so a pop never frees room for a same-cycle push.
    assign ready_c    = (count != CW'(RXDEPTH));
    assign nonempty_c = (count != '0);
    assign do_push    = push_valid & ready_c;
    assign do_pop     = pop & nonempty_c;
    assign head_c     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because RXDEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pico9_io_hub.sv
// Four-channel I/O hub on the Pico9 port bus: RX FIFOs, TX holding registers, status and irq.
// Define PICO9_IOHUB_SCHED_EN to build the port 6 round-robin scheduler.
module pico9_io_hub
    import pico9_pkg::*;
#(
    parameter int unsigned RXDEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PW-1:0]     port,
    input  logic              iord,
    input  logic              iowr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata,
    output logic              irq,
    input  logic [NCH-1:0]    rx_valid,
    input  logic [NCH*DW-1:0] rx_data,
    output logic [NCH-1:0]    rx_ready,
    output logic [NCH-1:0]    tx_valid,
    output logic [NCH*DW-1:0] tx_data,
    input  logic [NCH-1:0]    tx_ready
);

    logic          rd_en;
    logic          wr_en;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] nonempty;
    logic [DW-1:0]  head [NCH];
    logic [NCH-1:0] tx_load;
    logic [NCH-1:0] tx_drop;
    logic [NCH-1:0] ovr;
    logic [NCH-1:0] ovr_clr;
    logic [NCH-1:0] mask;
    logic [DW-1:0]  sched_word;

    // A simultaneous write wins; read side effects are suppressed.
    assign rd_en = iord & ~iowr;
    assign wr_en = iowr;

    for (genvar n = 0; n < NCH; n++) begin : g_rx
        assign pop[n] = rd_en && (port == PW'(n));

        pico9_rx_fifo #(
            .DW      (DW),
            .RXDEPTH (RXDEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .push_valid (rx_valid[n]),
            .push_data  (rx_data[n*DW +: DW]),
            .pop        (pop[n]),
            .ready_c    (rx_ready[n]),
            .nonempty_c (nonempty[n]),
            .head_c     (head[n])
        );
    end

    // TX load/drop decision uses tx_valid at cycle start, so a write racing a drain is dropped.
    always_comb begin
        tx_load = '0;
        tx_drop = '0;
        for (int n = 0; n < NCH; n++) begin
            if (wr_en && (port == PW'(n))) begin
                tx_load[n] = ~tx_valid[n];
                tx_drop[n] = tx_valid[n];
            end
        end
    end

    assign ovr_clr = (wr_en && (port == IO_OVR)) ? wdata[NCH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid <= '0;
            tx_data  <= '0;
            ovr      <= '0;
            mask     <= '1;
            irq      <= 1'b0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (tx_load[n]) begin
                    tx_valid[n]          <= 1'b1;
                    tx_data[n*DW +: DW]  <= wdata;
                end else if (tx_ready[n]) begin
                    tx_valid[n] <= 1'b0;
                end
            end
            ovr <= (ovr & ~ovr_clr) | tx_drop;
            if (wr_en && (port == IO_MASK)) begin
                mask <= wdata[NCH-1:0];
            end
            irq <= |(nonempty & mask);
        end
    end

`ifdef PICO9_IOHUB_SCHED_EN
    logic [1:0] last;
    logic [1:0] cand;
    logic [1:0] sched_ch;
    logic       sched_hit;

    // Search last+1 .. last+4 (mod 4); the final step revisits last itself.
    always_comb begin
        sched_hit = 1'b0;
        sched_ch  = last;
        cand      = last;
        for (int k = 1; k <= NCH; k++) begin
            cand = last + 2'(k);
            if (!sched_hit && nonempty[cand] && mask[cand]) begin
                sched_hit = 1'b1;
                sched_ch  = cand;
            end
        end
    end

    assign sched_word = sched_hit ? {1'b1, (DW-3)'(0), sched_ch} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 2'd3;
        end else if (rd_en && (port == IO_SCHED) && sched_hit) begin
            last <= sched_ch;
        end
    end
`else
    assign sched_word = '0;
`endif

    // Read mux: combinational, zero whenever no read strobe is present.
    always_comb begin
        rdata = '0;
        if (iord) begin
            case (port)
                IO_CH0, IO_CH1, IO_CH2, IO_CH3: begin
                    rdata = nonempty[port[1:0]] ? head[port[1:0]] : '0;
                end
                IO_STAT: begin
                    rdata[STAT_OVR_BIT]          = |ovr;
                    rdata[STAT_TXV_LSB +: NCH]   = tx_valid;
                    rdata[STAT_NE_LSB +: NCH]    = nonempty;
                end
                IO_MASK:  rdata = DW'(mask);
                IO_SCHED: rdata = sched_word;
                IO_OVR:   rdata = DW'(ovr);
                default:  rdata = '0;
            endcase
        end
    end

    // Only bit SCHED_HIT_BIT is meaningful as a flag; keep the constant tied to the word layout.
    logic unused_ok;
    assign unused_ok = (SCHED_HIT_BIT == DW - 1);

endmodule

// File: tb/tb_pico9_io_hub.sv
// Scoreboard bench for pico9_io_hub: stimulus queues expected values, a negedge monitor checks them.
module tb_pico9_io_hub;
    import pico9_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        port;
    logic              iord;
    logic              iowr;
    logic [8:0]        wdata;
    logic [8:0]        rdata;
    logic              irq;
    logic [3:0]        rx_valid;
    logic [35:0]       rx_data;
    logic [3:0]        rx_ready;
    logic [3:0]        tx_valid;
    logic [35:0]       tx_data;
    logic [3:0]        tx_ready;

    typedef enum int {P_RXRDY, P_TXV, P_IRQ, P_TXD1} psel_t;
    typedef struct {
        psel_t      sel;
        logic [8:0] val;
        string      name;
    } probe_t;
    typedef struct {
        logic [8:0] val;
        string      name;
    } rd_t;

    rd_t    rd_q[$];
    probe_t probe_q[$];
    logic   probe_req = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;

    pico9_io_hub #(.RXDEPTH(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .port     (port),
        .iord     (iord),
        .iowr     (iowr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Monitor: compares rdata on every read strobe and drains queued probes when asked.
    always @(negedge clk) begin
        if (iord) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read port=%0d got=0x%03h", port, rdata);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                if (rdata !== e.val) begin
                    n_err++;
                    $display("FAIL %s got=0x%03h want=0x%03h", e.name, rdata, e.val);
                end
            end
        end
        if (probe_req) begin
            while (probe_q.size() > 0) begin
                probe_t p;
                logic [8:0] act;
                p = probe_q.pop_front();
                case (p.sel)
                    P_RXRDY: act = {5'd0, rx_ready};
                    P_TXV:   act = {5'd0, tx_valid};
                    P_IRQ:   act = {8'd0, irq};
                    default: act = tx_data[1*9 +: 9];
                endcase
                n_vec++;
                if (act !== p.val) begin
                    n_err++;
                    $display("FAIL %s got=0x%03h want=0x%03h", p.name, act, p.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] p, input logic [8:0] exp, input string nm);
        rd_q.push_back('{val: exp, name: nm});
        port = p;
        iord = 1'b1;
        tick();
        iord = 1'b0;
    endtask

    task automatic wr(input logic [2:0] p, input logic [8:0] d);
        port  = p;
        wdata = d;
        iowr  = 1'b1;
        tick();
        iowr  = 1'b0;
    endtask

    task automatic expect_sig(input psel_t s, input logic [8:0] v, input string nm);
        probe_q.push_back('{sel: s, val: v, name: nm});
    endtask

    task automatic fire();
        probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
    endtask

    task automatic push(input int ch, input logic [8:0] v);
        rx_valid[ch]       = 1'b1;
        rx_data[ch*9 +: 9] = v;
        tick();
        rx_valid[ch]       = 1'b0;
    endtask

    function automatic logic [8:0] sx(input logic [8:0] v);
`ifdef PICO9_IOHUB_SCHED_EN
        return v;
`else
        return (v != 9'h000) ? 9'h000 : 9'h000;
`endif
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        port     = '0;
        iord     = 1'b0;
        iowr     = 1'b0;
        wdata    = '0;
        rx_valid = '0;
        rx_data  = '0;
        tx_ready = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        expect_sig(P_RXRDY, 9'h00F, "reset_rx_ready");
        expect_sig(P_IRQ,   9'h000, "reset_irq");
        expect_sig(P_TXV,   9'h000, "reset_tx_valid");
        fire();
        rd(IO_STAT,  9'h000, "reset_status");
        rd(IO_MASK,  9'h00F, "reset_mask");
        rd(IO_SCHED, 9'h000, "reset_sched_empty");
        rd(IO_OVR,   9'h000, "reset_ovr");

        // Fill channel 2, third word held off while full
        push(2, 9'h1A5);
        push(2, 9'h0F0);
        rx_valid[2] = 1'b1;
        rx_data[2*9 +: 9] = 9'h155;
        expect_sig(P_RXRDY, 9'h00B, "ch2_full_ready");
        fire();
        rx_valid[2] = 1'b0;
        expect_sig(P_IRQ, 9'h001, "irq_ch2");
        fire();
        rd(IO_STAT, 9'h004, "status_ch2_ne");
        rd(IO_CH2,  9'h1A5, "ch2_pop0");
        rd(IO_CH2,  9'h0F0, "ch2_pop1");
        rd(IO_CH2,  9'h000, "ch2_empty_read");
        rd(IO_STAT, 9'h000, "status_ch2_drained");
        expect_sig(P_RXRDY, 9'h00F, "ch2_ready_again");
        expect_sig(P_IRQ,   9'h000, "irq_cleared");
        fire();

        // Pointer wrap across several fills
        push(2, 9'h0AA);
        rd(IO_CH2, 9'h0AA, "wrap_a");
        push(2, 9'h0BB);
        push(2, 9'h0CC);
        rd(IO_CH2, 9'h0BB, "wrap_b");
        rd(IO_CH2, 9'h0CC, "wrap_c");

        // Push and pop same cycle on an empty FIFO: push lands, read returns 0
        rx_valid[2] = 1'b1;
        rx_data[2*9 +: 9] = 9'h0DD;
        rd(IO_CH2, 9'h000, "empty_push_pop");
        rx_valid[2] = 1'b0;
        push(2, 9'h0EE);
        // Full: same-cycle pop does not make room
        rx_valid[2] = 1'b1;
        rx_data[2*9 +: 9] = 9'h0FF;
        rd(IO_CH2, 9'h0DD, "full_push_pop");
        rx_valid[2] = 1'b0;
        rd(IO_CH2, 9'h0EE, "full_after");
        rd(IO_CH2, 9'h000, "full_push_rejected");

        // TX holding register and overrun
        wr(IO_CH1, 9'h133);
        expect_sig(P_TXV,  9'h002, "tx1_loaded");
        expect_sig(P_TXD1, 9'h133, "tx1_data");
        fire();
        wr(IO_CH1, 9'h044);
        expect_sig(P_TXD1, 9'h133, "tx1_drop_keeps");
        fire();
        rd(IO_OVR,  9'h002, "ovr_set");
        rd(IO_STAT, 9'h120, "status_tx_ovr");
        wr(IO_OVR, 9'h002);
        rd(IO_OVR, 9'h000, "ovr_cleared");

        // Write racing a drain is still dropped
        tx_ready[1] = 1'b1;
        wr(IO_CH1, 9'h044);
        tx_ready[1] = 1'b0;
        expect_sig(P_TXV,  9'h000, "tx1_drained");
        expect_sig(P_TXD1, 9'h133, "tx1_race_no_load");
        fire();
        rd(IO_OVR, 9'h002, "ovr_race");
        wr(IO_OVR, 9'h00F);
        wr(IO_CH1, 9'h044);
        expect_sig(P_TXV,  9'h002, "tx1_reload");
        expect_sig(P_TXD1, 9'h044, "tx1_reload_data");
        fire();
        rd(IO_OVR, 9'h000, "ovr_none_reload");

        // Scheduler: channels 0 and 3 non-empty
        rx_valid = 4'b1001;
        rx_data[0*9 +: 9] = 9'h011;
        rx_data[3*9 +: 9] = 9'h033;
        tick();
        rx_valid = '0;
        rd(IO_STAT,  9'h029, "status_ch0_ch3");
        rd(IO_SCHED, sx(9'h100), "sched_f_0");
        rd(IO_SCHED, sx(9'h103), "sched_f_3");
        rd(IO_SCHED, sx(9'h100), "sched_f_0b");
        wr(IO_MASK, 9'h008);
        rd(IO_SCHED, sx(9'h103), "sched_8_a");
        rd(IO_SCHED, sx(9'h103), "sched_8_b");
        wr(IO_MASK, 9'h000);
        rd(IO_SCHED, 9'h000, "sched_mask0");
        expect_sig(P_IRQ, 9'h000, "irq_masked");
        fire();
        wr(IO_MASK, 9'h00F);
        tick();
        expect_sig(P_IRQ, 9'h001, "irq_unmasked");
        fire();

        // Asynchronous reset mid-transfer
        reset_n = 1'b0;
        rx_valid[0] = 1'b1;
        rx_data[0*9 +: 9] = 9'h1EE;
        expect_sig(P_RXRDY, 9'h00F, "rst_rx_ready");
        expect_sig(P_TXV,   9'h000, "rst_tx_valid");
        expect_sig(P_TXD1,  9'h000, "rst_tx_data");
        expect_sig(P_IRQ,   9'h000, "rst_irq");
        fire();
        reset_n = 1'b1;
        rx_valid = '0;
        rd(IO_CH0,  9'h000, "rst_ch0_empty");
        rd(IO_STAT, 9'h000, "rst_status");
        rd(IO_MASK, 9'h00F, "rst_mask");

        // Scheduler pointer restarts at 3, so channel 0 is found first
        rx_valid = 4'b1001;
        tick();
        rx_valid = '0;
        rd(IO_SCHED, sx(9'h100), "rst_sched_ptr");

        tick();
        tick();
        if (rd_q.size() != 0 || probe_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expectations rd=%0d probe=%0d want=0", rd_q.size(), probe_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
